// File: rtl/enc_xfm_coeff_pack_pkg.sv
// Shared encoder definitions for the 8x2 K444 transform-coefficient packer:
// block/group geometry, the forward EC index map and the bits-required rule.
package enc_xfm_coeff_pack_pkg;

  localparam int COEF_W   = 9;
  localparam int GRP_SIZE = 4;
  localparam int GRP_CNT  = 4;
  localparam int BLK_SIZE = GRP_SIZE * GRP_CNT;
  localparam int BITS_W   = 4;
  localparam int SIZE_W   = 8;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t [GRP_SIZE-1:0]     grp_t;
  typedef coef_t [BLK_SIZE-1:0]     blk_t;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_t;

  // Raster index feeding each EC position; EC position 0 sits in the low nibble.
  localparam logic [4*BLK_SIZE-1:0] FWD_MAP = {
    4'd15, 4'd14, 4'd13, 4'd12, 4'd7, 4'd6, 4'd5, 4'd11,
    4'd10, 4'd9,  4'd4,  4'd3,  4'd8, 4'd2, 4'd1, 4'd0
  };

  function automatic logic [3:0] fwd_map(input int unsigned ec);
    return FWD_MAP[4*ec +: 4];
  endfunction

  // Two's-complement width of one coefficient; zero needs no bits, -1 needs one.
  function automatic logic [BITS_W-1:0] coef_bits(input coef_t c);
    logic [COEF_W-2:0] mag;
    logic [BITS_W-1:0] n;
    mag = c[COEF_W-1] ? ~c[COEF_W-2:0] : c[COEF_W-2:0];
    n   = c[COEF_W-1] ? BITS_W'(1) : BITS_W'(0);
    for (int b = 0; b < COEF_W-1; b++) begin
      if (mag[b]) n = BITS_W'(b + 2);
    end
    return n;
  endfunction

  function automatic logic [BITS_W-1:0] grp_bits_req(input grp_t g);
    logic [BITS_W-1:0] n;
    logic [BITS_W-1:0] nc;
    n = '0;
    for (int i = 0; i < GRP_SIZE; i++) begin
      nc = coef_bits(g[i]);
      if (nc > n) n = nc;
    end
    return n;
  endfunction

endpackage

// File: rtl/enc_xfm_coeff_pack_if.sv
// Block-in / group-beat-out handshake bundle of the transform-coefficient packer.
interface enc_xfm_coeff_pack_if;
  import enc_xfm_coeff_pack_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                mode_XFM;
  blk_t                in_coeff;
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          out_grp_idx;
  logic [BITS_W-1:0]   out_bits_req;
  grp_t                out_coeff;
  logic                out_last;
  logic [SIZE_W-1:0]   coef_size;

  modport slave (
    input  in_valid, mode_XFM, in_coeff, out_ready,
    output in_ready, out_valid, out_grp_idx, out_bits_req, out_coeff, out_last, coef_size
  );

  modport master (
    output in_valid, mode_XFM, in_coeff, out_ready,
    input  in_ready, out_valid, out_grp_idx, out_bits_req, out_coeff, out_last, coef_size
  );

endinterface

// File: rtl/enc_grp_bits_req.sv
// Bits-required of one four-coefficient EC group; purely combinational so any
// ECG mode can drop it in front of its suffix writer.
module enc_grp_bits_req
  import enc_xfm_coeff_pack_pkg::*;
(
  input  grp_t              grp,
  output logic [BITS_W-1:0] bits_req
);

  assign bits_req = grp_bits_req(grp);

endmodule

// File: rtl/enc_xfm_coeff_pack.sv
// Captures a raster block in EC order and streams its four groups, with their
// bits-required and the running suffix size, to the ECG suffix writer.
module enc_xfm_coeff_pack
  import enc_xfm_coeff_pack_pkg::*;
#(
  parameter int unsigned ssm_idx = 0,
  parameter int unsigned comp    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  enc_xfm_coeff_pack_if.slave   xif
);

  if (ssm_idx > 15 || comp > 3) begin : g_id_range
    $error("enc_xfm_coeff_pack: instance id out of range");
  end

  state_t            state_q, state_d;
  logic [1:0]        grp_q, grp_d;
  blk_t              coef_buf_q;
  logic [SIZE_W-1:0] size_acc_q;

  grp_t              cur_grp;
  logic [BITS_W-1:0] cur_bits;
  logic              last_grp;
  logic              beat_done;
  logic              load;
  logic [SIZE_W-1:0] cur_size;

  always_comb begin
    cur_grp = '0;
    for (int j = 0; j < GRP_SIZE; j++) begin
      cur_grp[j] = coef_buf_q[{grp_q, 2'(j)}];
    end
  end

  enc_grp_bits_req u_grp_bits_req (
    .grp      (cur_grp),
    .bits_req (cur_bits)
  );

  assign cur_size = {2'b00, cur_bits, 2'b00};

  // Next-state and handshake outputs; beat fields are zeroed whenever no beat is offered.
  always_comb begin
    state_d          = state_q;
    grp_d            = grp_q;
    last_grp         = (grp_q == 2'(GRP_CNT-1));
    beat_done        = (state_q == ST_EMIT) && xif.out_ready;
    xif.in_ready     = (state_q == ST_IDLE) || (last_grp && beat_done);
    load             = xif.in_valid && xif.in_ready && xif.mode_XFM;
    xif.out_valid    = (state_q == ST_EMIT);
    xif.out_grp_idx  = 2'b00;
    xif.out_bits_req = '0;
    xif.out_coeff    = '0;
    xif.out_last     = 1'b0;
    xif.coef_size    = size_acc_q;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_EMIT;
          grp_d   = 2'b00;
        end
      end
      ST_EMIT: begin
        xif.out_grp_idx  = grp_q;
        xif.out_bits_req = cur_bits;
        xif.out_coeff    = cur_grp;
        xif.out_last     = last_grp;
        xif.coef_size    = size_acc_q + cur_size;
        if (xif.out_ready) begin
          if (!last_grp) begin
            grp_d = grp_q + 2'b01;
          end else begin
            grp_d   = 2'b00;
            state_d = load ? ST_EMIT : ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grp_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grp_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
    end
  end

  // Block capture in EC order; the size accumulator restarts on every load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_buf_q <= '0;
      size_acc_q <= '0;
    end else if (load) begin
      for (int e = 0; e < BLK_SIZE; e++) begin
        coef_buf_q[e] <= xif.in_coeff[fwd_map(e)];
      end
      size_acc_q <= '0;
    end else if (beat_done) begin
      size_acc_q <= size_acc_q + cur_size;
    end
  end

endmodule

// File: tb/tb_enc_xfm_coeff_pack.sv
// Directed bench for enc_xfm_coeff_pack: ramp, zero and spike blocks, stalls,
// back-to-back reload, non-transform blocks and a mid-block reset.
module tb_enc_xfm_coeff_pack;
  import enc_xfm_coeff_pack_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  enc_xfm_coeff_pack_if xif ();

  enc_xfm_coeff_pack #(.ssm_idx(0), .comp(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .xif   (xif.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] g4(input int a, input int b, input int c, input int d);
    return {9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  function automatic blk_t ramp_blk();
    blk_t b;
    for (int k = 0; k < BLK_SIZE; k++) b[k] = coef_t'(k);
    return b;
  endfunction

  // raster 0 = -256; raster 3, 11, 12 = -1 land at the head of groups 1..3
  function automatic blk_t spike_blk();
    blk_t b;
    b     = '0;
    b[0]  = -9'sd256;
    b[3]  = -9'sd1;
    b[11] = -9'sd1;
    b[12] = -9'sd1;
    return b;
  endfunction

  task automatic beat(input string tag, input int g, input int bits,
                      input logic [35:0] coeffs, input logic last, input int size);
    chk({tag, ".valid"}, 64'(xif.out_valid), 64'd1);
    chk({tag, ".grp"},   64'(xif.out_grp_idx), 64'(g));
    chk({tag, ".bits"},  64'(xif.out_bits_req), 64'(bits));
    chk({tag, ".coeff"}, 64'(xif.out_coeff), 64'(coeffs));
    chk({tag, ".last"},  64'(xif.out_last), 64'(last));
    if (size >= 0) chk({tag, ".size"}, 64'(xif.coef_size), 64'(size));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".in_ready"},  64'(xif.in_ready), 64'd1);
    chk({tag, ".out_valid"}, 64'(xif.out_valid), 64'd0);
    chk({tag, ".out_last"},  64'(xif.out_last), 64'd0);
    chk({tag, ".grp"},       64'(xif.out_grp_idx), 64'd0);
    chk({tag, ".bits"},      64'(xif.out_bits_req), 64'd0);
    chk({tag, ".coeff"},     64'(xif.out_coeff), 64'd0);
    chk({tag, ".size"},      64'(xif.coef_size), 64'd0);
  endtask

  task automatic offer(input blk_t b, input logic xfm);
    xif.in_valid = 1'b1;
    xif.mode_XFM = xfm;
    xif.in_coeff = b;
  endtask

  initial begin
    rst_n         = 1'b0;
    xif.in_valid  = 1'b0;
    xif.mode_XFM  = 1'b0;
    xif.in_coeff  = '0;
    xif.out_ready = 1'b1;
    tick();
    tick();
    chk_reset_outs("reset");
    rst_n = 1'b1;
    tick();

    // Ramp block, continuous ready
    offer(ramp_blk(), 1'b1);
    #1 chk("ramp.in_ready", 64'(xif.in_ready), 64'd1);
    tick();
    xif.in_valid = 1'b0;
    beat("ramp.g0", 0, 5, g4(0, 1, 2, 8), 1'b0, -1);
    tick();
    beat("ramp.g1", 1, 5, g4(3, 4, 9, 10), 1'b0, -1);
    tick();
    beat("ramp.g2", 2, 5, g4(11, 5, 6, 7), 1'b0, -1);
    tick();
    beat("ramp.g3", 3, 5, g4(12, 13, 14, 15), 1'b1, 80);
    tick();
    chk("ramp.idle_valid", 64'(xif.out_valid), 64'd0);
    chk("ramp.idle_ready", 64'(xif.in_ready), 64'd1);
    chk("ramp.held_size",  64'(xif.coef_size), 64'd80);

    // All-zero block
    offer('0, 1'b1);
    tick();
    xif.in_valid = 1'b0;
    beat("zero.g0", 0, 0, g4(0, 0, 0, 0), 1'b0, 0);
    tick();
    beat("zero.g1", 1, 0, g4(0, 0, 0, 0), 1'b0, -1);
    tick();
    beat("zero.g2", 2, 0, g4(0, 0, 0, 0), 1'b0, -1);
    tick();
    beat("zero.g3", 3, 0, g4(0, 0, 0, 0), 1'b1, 0);
    tick();

    // Spike block
    offer(spike_blk(), 1'b1);
    tick();
    xif.in_valid = 1'b0;
    beat("spike.g0", 0, 9, g4(-256, 0, 0, 0), 1'b0, -1);
    tick();
    beat("spike.g1", 1, 1, g4(-1, 0, 0, 0), 1'b0, -1);
    tick();
    beat("spike.g2", 2, 1, g4(-1, 0, 0, 0), 1'b0, -1);
    tick();
    beat("spike.g3", 3, 1, g4(-1, 0, 0, 0), 1'b1, 48);
    tick();
    chk("spike.idle_valid", 64'(xif.out_valid), 64'd0);

    // Stall on group 1, then back-to-back reload during the final beat
    offer(ramp_blk(), 1'b1);
    tick();
    xif.in_valid = 1'b0;
    beat("stall.g0", 0, 5, g4(0, 1, 2, 8), 1'b0, -1);
    tick();
    xif.out_ready = 1'b0;
    #1 beat("stall.g1a", 1, 5, g4(3, 4, 9, 10), 1'b0, -1);
    chk("stall.in_ready", 64'(xif.in_ready), 64'd0);
    tick();
    beat("stall.g1b", 1, 5, g4(3, 4, 9, 10), 1'b0, -1);
    tick();
    beat("stall.g1c", 1, 5, g4(3, 4, 9, 10), 1'b0, -1);
    xif.out_ready = 1'b1;
    tick();
    beat("stall.g2", 2, 5, g4(11, 5, 6, 7), 1'b0, -1);
    tick();
    offer(spike_blk(), 1'b1);
    #1 beat("stall.g3", 3, 5, g4(12, 13, 14, 15), 1'b1, 80);
    chk("b2b.in_ready", 64'(xif.in_ready), 64'd1);
    tick();
    xif.in_valid = 1'b0;
    beat("b2b.g0", 0, 9, g4(-256, 0, 0, 0), 1'b0, 36);
    tick();
    beat("b2b.g1", 1, 1, g4(-1, 0, 0, 0), 1'b0, -1);
    tick();
    beat("b2b.g2", 2, 1, g4(-1, 0, 0, 0), 1'b0, -1);
    tick();
    beat("b2b.g3", 3, 1, g4(-1, 0, 0, 0), 1'b1, 48);
    tick();

    // Non-transform block is consumed without beats
    offer(ramp_blk(), 1'b0);
    #1 chk("nxfm.in_ready", 64'(xif.in_ready), 64'd1);
    tick();
    xif.in_valid = 1'b0;
    chk("nxfm.valid0", 64'(xif.out_valid), 64'd0);
    chk("nxfm.ready0", 64'(xif.in_ready), 64'd1);
    tick();
    chk("nxfm.valid1", 64'(xif.out_valid), 64'd0);

    // Reset while group 2 is presented
    offer(ramp_blk(), 1'b1);
    tick();
    xif.in_valid = 1'b0;
    tick();
    tick();
    chk("rst.pre_grp", 64'(xif.out_grp_idx), 64'd2);
    rst_n = 1'b0;
    #1 chk_reset_outs("rst.async");
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset_outs("rst.after");
    offer(spike_blk(), 1'b1);
    tick();
    xif.in_valid = 1'b0;
    beat("post.g0", 0, 9, g4(-256, 0, 0, 0), 1'b0, -1);
    tick();
    beat("post.g1", 1, 1, g4(-1, 0, 0, 0), 1'b0, -1);
    tick();
    beat("post.g2", 2, 1, g4(-1, 0, 0, 0), 1'b0, -1);
    tick();
    beat("post.g3", 3, 1, g4(-1, 0, 0, 0), 1'b1, 48);
    tick();
    chk("post.idle_valid", 64'(xif.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
